fpu_move_sequencer: RTL and testbench
=====================================

Name: fpu_move_sequencer

Overview:
- Arbitrates two move requesters onto the single combinational FP move datapath and sequences each transfer: requester 0 is integer→FP (FMV.W.X), requester 1 is FP→integer (FMV.X.W).
- Drives the datapath opcode and operand, then captures its result into a small response FIFO.
- Returns each result with its tag and direction.
- Sits between the FPU decode/issue stage and the move datapath, inside the FPU top.

Parameters:
- DATA_W, 32, operand/result width (IEEE754 single).
- TAG_W, 5, destination-register tag width.
- RSP_DEPTH, 2, response FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  clock
- rst_l  input  1  synchronous active-high reset
- flush  input  1  synchronous pipeline flush
- req0_valid  input  1  int→FP request valid
- req0_ready  output  1  int→FP request accepted
- req0_data  input  DATA_W  int→FP operand
- req0_tag  input  TAG_W  int→FP destination tag
- req1_valid  input  1  FP→int request valid
- req1_ready  output  1  FP→int request accepted
- req1_data  input  DATA_W  FP→int operand
- req1_tag  input  TAG_W  FP→int destination tag
- mv_opcode  output  2  datapath opcode
- mv_in  output  DATA_W  datapath operand
- mv_out  input  DATA_W  datapath result (combinational from mv_opcode/mv_in)
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response consumer ready
- rsp_data  output  DATA_W  moved value
- rsp_tag  output  TAG_W  tag of moved value
- rsp_dir  output  1  0 = int→FP, 1 = FP→int
- busy  output  1  a transfer is in flight or the FIFO is non-empty

Behaviour:
- Reset (rst_l=1 at a clk edge):
  - State→IDLE, FIFO empty, round-robin pointer→favour req0.
  - All outputs 0: mv_opcode=2'b00, mv_in=0, rsp_*=0, ready=0, busy=0.
- Handshake: a transfer occurs when valid&&ready at a clk edge. Requesters must hold data/tag stable while valid. Ready is never asserted to both requesters in the same cycle.
- Grant:
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - The pointer updates only on an actual accept.
- FSM:
  - IDLE: ready to the winner is asserted. On accept, latch operand, tag and direction → ISSUE.
  - ISSUE: drive mv_opcode (2'b10 for req0, 2'b01 for req1) and mv_in = latched operand.
    - If the FIFO has space this cycle (count<RSP_DEPTH, or a pop happens the same cycle), push {mv_out, tag, dir}.
    - A new winner may be accepted in this same cycle (stay ISSUE); otherwise → IDLE.
    - If there is no space → WAIT; ready=0.
  - WAIT: keep driving the same opcode/operand. Push when space frees (a same-cycle pop counts) → IDLE. No accepts in WAIT.
- mv_opcode=2'b00 and mv_in=0 whenever the state is IDLE.
- Latency and throughput:
  - Accept at edge N; push at edge N+1; rsp_valid high after edge N+1 when the FIFO was empty.
  - Sustained throughput is 1 move/cycle.
- FIFO:
  - rsp_* shows the head entry; pop on rsp_valid&&rsp_ready.
  - Pointers wrap modulo RSP_DEPTH.
  - Push and pop together at full or empty are legal; count is unchanged.
  - No push while full.
- flush: state→IDLE, FIFO emptied, latched transfer dropped, no accept that cycle, pointer unchanged. rst_l has priority over flush.
- busy = (state≠IDLE) || (count≠0).

Optional Feature:
- FPU_MOVE_PERF_CNT_EN.
- Defined: adds outputs perf_mv_cnt0 and perf_mv_cnt1, each 32 bits, counting pushes per direction.
  - Counters wrap at 2^32.
  - Cleared by rst_l only; not cleared by flush.
  - A pushed entry is counted even if it is later flushed.
- Undefined: the ports and counters are absent; there is no behavioural difference otherwise.

Decomposition:
- Shared package (fpu_move_pkg):
  - State enum IDLE/ISSUE/WAIT.
  - Opcode constants MV_OP_NONE=2'b00, MV_OP_X2F=2'b10, MV_OP_F2X=2'b01.
  - Direction constants DIR_X2F=0, DIR_F2X=1.
- One natural sub-module: fpu_move_rsp_fifo, the parameterised sync FIFO with push/pop/count. The arbiter and FSM stay in the top.

Test Plan:
- Reset then idle: rst_l=1 for 2 cycles → all outputs 0; after release with no valid → mv_opcode=00, busy=0.
- Single move: req0 valid, data 0x3F800000, tag 5 → accept edge N; mv_opcode=10, mv_in=0x3F800000 in cycle N+1; rsp_valid after N+1 with data 0x3F800000, tag 5, dir 0.
- Contention: both valid continuously, rsp_ready=1 → grants alternate req0, req1, req0, req1; rsp_dir sequence 0,1,0,1; one response/cycle.
- Backpressure: rsp_ready=0, three req1 moves (0x1, 0x2, 0x3) → two enter the FIFO, third holds in WAIT with mv_opcode=01, mv_in=0x3; raise rsp_ready → responses 0x1, 0x2, 0x3 in order.
- Flush mid-operation: flush asserted in WAIT with FIFO full → next cycle rsp_valid=0, busy=0, state IDLE; next request completes normally.
- Perf counters (macro defined): 3 req0 moves + 2 req1 moves → perf_mv_cnt0=3, perf_mv_cnt1=2; flush leaves them unchanged.

Source files
------------

// File: rtl/fpu_move_pkg.sv
// Shared constants for the FP move sequencer: FSM states, datapath opcodes, directions.
package fpu_move_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  localparam logic [1:0] MV_OP_NONE = 2'b00;
  localparam logic [1:0] MV_OP_X2F  = 2'b10;
  localparam logic [1:0] MV_OP_F2X  = 2'b01;

  localparam logic DIR_X2F = 1'b0;
  localparam logic DIR_F2X = 1'b1;

endpackage

// File: rtl/fpu_move_sequencer_if.sv
// Request, datapath and response bundle of the FP move sequencer.
// slave = the sequencer; master = issue stage, move datapath and response consumer.
interface fpu_move_sequencer_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [TAG_W-1:0]  req0_tag;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [TAG_W-1:0]  req1_tag;
  logic [1:0]        mv_opcode;
  logic [DATA_W-1:0] mv_in;
  logic [DATA_W-1:0] mv_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_dir;
  logic              busy;

  modport slave (
    input  req0_valid, req0_data, req0_tag, req1_valid, req1_data, req1_tag,
    input  mv_out, rsp_ready,
    output req0_ready, req1_ready, mv_opcode, mv_in,
    output rsp_valid, rsp_data, rsp_tag, rsp_dir, busy
  );

  modport master (
    output req0_valid, req0_data, req0_tag, req1_valid, req1_data, req1_tag,
    output mv_out, rsp_ready,
    input  req0_ready, req1_ready, mv_opcode, mv_in,
    input  rsp_valid, rsp_data, rsp_tag, rsp_dir, busy
  );
endinterface

// File: rtl/fpu_move_rsp_fifo.sv
// Sync response FIFO with occupancy count; flush empties it.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: push accepted when not full or when a pop happens the same cycle.
module fpu_move_rsp_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         flush,
  input  logic                         push,
  input  logic [W-1:0]                 push_dat,
  input  logic                         pop,
  output logic [W-1:0]                 head_dat,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_eff;
  logic          push_eff;

  assign pop_eff  = pop && (count != '0);
  assign push_eff = push && ((count != FULL_CNT) || pop_eff);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst_l || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_eff) mem[wr_ptr] <= push_dat;
  end
endmodule

// File: rtl/fpu_move_sequencer.sv
// Round-robin arbiter + IDLE/ISSUE/WAIT sequencer for int<->FP moves; optional FPU_MOVE_PERF_CNT_EN counters.
// Latency: accept at edge N, result pushed at N+1; sustains one move per cycle.
// Backpressure: stalls in WAIT (no accepts) while the response FIFO is full.
module fpu_move_sequencer
  import fpu_move_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 5,
  parameter int RSP_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 flush,
  fpu_move_sequencer_if.slave  bus
`ifdef FPU_MOVE_PERF_CNT_EN
  ,
  output logic [31:0]          perf_mv_cnt0,
  output logic [31:0]          perf_mv_cnt1
`endif
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int EW = DATA_W + TAG_W + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);

  logic [1:0]        state;
  logic [DATA_W-1:0] lat_data;
  logic [TAG_W-1:0]  lat_tag;
  logic              lat_dir;
  logic              pri1;
  logic [CW-1:0]     rsp_count;
  logic [EW-1:0]     head;
  logic              active;
  logic              pop;
  logic              space;
  logic              push;
  logic              accept_en;
  logic              acc0;
  logic              acc1;

  assign active    = (state == ST_ISSUE) || (state == ST_WAIT);
  assign pop       = bus.rsp_valid && bus.rsp_ready;
  assign space     = (rsp_count != FULL_CNT) || pop;
  assign push      = active && space && !flush;
  assign accept_en = !rst_l && !flush &&
                     ((state == ST_IDLE) || ((state == ST_ISSUE) && space));

  // pri1 set means req0 won last, so req1 takes a contested grant.
  assign bus.req0_ready = accept_en && bus.req0_valid && !(bus.req1_valid && pri1);
  assign bus.req1_ready = accept_en && bus.req1_valid && !(bus.req0_valid && !pri1);
  assign acc0 = bus.req0_valid && bus.req0_ready;
  assign acc1 = bus.req1_valid && bus.req1_ready;

  assign bus.mv_opcode = !active ? MV_OP_NONE : (lat_dir == DIR_F2X) ? MV_OP_F2X : MV_OP_X2F;
  assign bus.mv_in     = active ? lat_data : '0;

  assign bus.rsp_valid = (rsp_count != '0);
  assign bus.rsp_data  = bus.rsp_valid ? head[EW-1:TAG_W+1] : '0;
  assign bus.rsp_tag   = bus.rsp_valid ? head[TAG_W:1] : '0;
  assign bus.rsp_dir   = bus.rsp_valid && head[0];
  assign bus.busy      = active || (rsp_count != '0);

  always_ff @(posedge clk) begin
    if (rst_l) begin
      state    <= ST_IDLE;
      pri1     <= 1'b0;
      lat_data <= '0;
      lat_tag  <= '0;
      lat_dir  <= DIR_X2F;
    end else if (flush) begin
      state <= ST_IDLE;
    end else begin
      if (acc0 || acc1) begin
        lat_data <= acc1 ? bus.req1_data : bus.req0_data;
        lat_tag  <= acc1 ? bus.req1_tag : bus.req0_tag;
        lat_dir  <= acc1 ? DIR_F2X : DIR_X2F;
        pri1     <= acc0;
      end
      case (state)
        ST_IDLE:  if (acc0 || acc1) state <= ST_ISSUE;
        ST_ISSUE: state <= !space ? ST_WAIT : (acc0 || acc1) ? ST_ISSUE : ST_IDLE;
        ST_WAIT:  if (space) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  fpu_move_rsp_fifo #(
    .W     (EW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .flush    (flush),
    .push     (push),
    .push_dat ({bus.mv_out, lat_tag, lat_dir}),
    .pop      (pop),
    .head_dat (head),
    .count    (rsp_count)
  );

`ifdef FPU_MOVE_PERF_CNT_EN
  // Counted at push time, so entries later discarded by flush still count.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      perf_mv_cnt0 <= '0;
      perf_mv_cnt1 <= '0;
    end else if (push) begin
      if (lat_dir == DIR_F2X) perf_mv_cnt1 <= perf_mv_cnt1 + 32'd1;
      else                    perf_mv_cnt0 <= perf_mv_cnt0 + 32'd1;
    end
  end
`else
  // Without counters, push events are consumed only by the FIFO.
`endif
endmodule

// File: tb/tb_fpu_move_sequencer.sv
// Randomized and directed bench for fpu_move_sequencer against an in-order transfer queue model.
module tb_fpu_move_sequencer;
  import fpu_move_pkg::*;

  localparam int DW    = 32;
  localparam int TW    = 5;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic          dir;
  } xfer_t;

  logic clk = 1'b0;
  logic rst_l;
  logic flush;
  always #5 clk = ~clk;

  fpu_move_sequencer_if #(.DATA_W(DW), .TAG_W(TW)) bus();
`ifdef FPU_MOVE_PERF_CNT_EN
  logic [31:0] perf_mv_cnt0;
  logic [31:0] perf_mv_cnt1;
`endif

  fpu_move_sequencer #(.DATA_W(DW), .TAG_W(TW), .RSP_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .flush (flush),
    .bus   (bus)
`ifdef FPU_MOVE_PERF_CNT_EN
    ,
    .perf_mv_cnt0 (perf_mv_cnt0),
    .perf_mv_cnt1 (perf_mv_cnt1)
`endif
  );

  // FMV is a bit copy; an illegal opcode yields a poison value.
  always_comb bus.mv_out = (bus.mv_opcode == MV_OP_X2F || bus.mv_opcode == MV_OP_F2X) ?
                           bus.mv_in : 32'hBAD0_BAD0;

  int    total = 0;
  int    bad   = 0;
  xfer_t exp_q[$];
  logic  last_dir = 1'b1;
  logic  s_acc0, s_acc1, s_both_rdy, s_pop, s_flush, s_exp_win1;
  xfer_t s_rsp;

  // Samples handshakes before the edge and updates the transfer-order model.
  task automatic clk_step();
    #2;
    s_acc0     = bus.req0_valid && bus.req0_ready;
    s_acc1     = bus.req1_valid && bus.req1_ready;
    s_both_rdy = bus.req0_ready && bus.req1_ready;
    s_pop      = bus.rsp_valid && bus.rsp_ready;
    s_rsp      = {bus.rsp_data, bus.rsp_tag, bus.rsp_dir};
    s_flush    = flush;
    s_exp_win1 = bus.req1_valid && (!bus.req0_valid || !last_dir);
    if (rst_l) begin
      exp_q.delete();
      last_dir = 1'b1;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (s_acc0) begin exp_q.push_back({bus.req0_data, bus.req0_tag, DIR_X2F}); last_dir = 1'b0; end
      if (s_acc1) begin exp_q.push_back({bus.req1_data, bus.req1_tag, DIR_F2X}); last_dir = 1'b1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_l = 1'b1; flush = 1'b0; bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 32'h1234_5678; bus.req0_tag = 5'd3;
    bus.req1_valid = 1'b1; bus.req1_data = 32'h8765_4321; bus.req1_tag = 5'd4;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b exp=00", {bus.req0_ready, bus.req1_ready});
    end
    total++;
    if ({bus.mv_opcode, bus.mv_in} !== '0) begin
      bad++; $display("FAIL reset_mv got=%b/%h exp=0", bus.mv_opcode, bus.mv_in);
    end
    total++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_dir, bus.busy} !== '0) begin
      bad++; $display("FAIL reset_rsp got=%b %h %h %b busy=%b exp=0", bus.rsp_valid,
                      bus.rsp_data, bus.rsp_tag, bus.rsp_dir, bus.busy);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    rst_l = 1'b0;
    clk_step();
    clk_step();
    total++;
    if ({bus.mv_opcode, bus.busy} !== 3'b000) begin
      bad++; $display("FAIL idle_after_reset got op=%b busy=%b exp=00/0", bus.mv_opcode, bus.busy);
    end
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    total++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      bad++; $display("FAIL reset_pointer got=%b exp=10", {bus.req0_ready, bus.req1_ready});
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  task automatic test_single();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_data = 32'h3F80_0000; bus.req0_tag = 5'd5;
    clk_step();
    bus.req0_valid = 1'b0;
    total++;
    if (s_acc0 !== 1'b1) begin bad++; $display("FAIL single_accept got=%b exp=1", s_acc0); end
    total++;
    if ({bus.mv_opcode, bus.mv_in, bus.rsp_valid} !== {2'b10, 32'h3F80_0000, 1'b0}) begin
      bad++; $display("FAIL single_issue got op=%b in=%h rv=%b exp op=10 in=3f800000 rv=0",
                      bus.mv_opcode, bus.mv_in, bus.rsp_valid);
    end
    clk_step();
    total++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_dir, bus.mv_opcode} !==
        {1'b1, 32'h3F80_0000, 5'd5, 1'b0, 2'b00}) begin
      bad++; $display("FAIL single_rsp got v=%b d=%h t=%0d dir=%b op=%b exp 1 3f800000 5 0 00",
                      bus.rsp_valid, bus.rsp_data, bus.rsp_tag, bus.rsp_dir, bus.mv_opcode);
    end
    bus.rsp_ready = 1'b1;
    clk_step();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    total++;
    if ({s_pop, bus.rsp_valid, bus.busy} !== 3'b100) begin
      bad++; $display("FAIL single_drain got pop=%b rv=%b busy=%b exp 1 0 0", s_pop, bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_contention();
    int n_acc = 0;
    int n_pop = 0;
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = $urandom; bus.req0_tag = 5'($urandom);
    bus.req1_valid = 1'b1; bus.req1_data = $urandom; bus.req1_tag = 5'($urandom);
    for (int i = 0; i < 12; i++) begin
      clk_step();
      total++;
      if ((s_acc0 ^ s_acc1) !== 1'b1) begin
        bad++; $display("FAIL cont_one_grant cyc=%0d got acc0=%b acc1=%b exp exactly one", i, s_acc0, s_acc1);
      end else begin
        total++;
        if (s_acc1 !== s_exp_win1) begin
          bad++; $display("FAIL cont_rr cyc=%0d got req%0d exp req%0d", i, s_acc1, s_exp_win1);
        end
        n_acc++;
      end
      if (s_pop) begin
        n_pop++;
        total++;
        if (exp_q.size() == 0 || s_rsp !== exp_q[0]) begin
          bad++; $display("FAIL cont_rsp got=%h exp=%h", s_rsp, exp_q.size() ? exp_q[0] : '0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_acc0) begin bus.req0_data = $urandom; bus.req0_tag = 5'($urandom); end
      if (s_acc1) begin bus.req1_data = $urandom; bus.req1_tag = 5'($urandom); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    total++;
    if (n_acc != 12 || n_pop != 10) begin
      bad++; $display("FAIL cont_throughput got acc=%0d pop=%0d exp 12/10", n_acc, n_pop);
    end
    for (int c = 0; c < 8 && bus.busy; c++) begin
      clk_step();
      if (s_pop) begin
        total++;
        if (exp_q.size() == 0 || s_rsp !== exp_q[0]) begin
          bad++; $display("FAIL cont_drain got=%h exp=%h", s_rsp, exp_q.size() ? exp_q[0] : '0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    total++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL cont_empty got left=%0d busy=%b exp 0/0", exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic got;
    bus.rsp_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.req1_valid = 1'b1; bus.req1_data = 32'(i); bus.req1_tag = 5'(i + 8);
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin clk_step(); got = s_acc1; end
      total++;
      if (!got) begin bad++; $display("FAIL bp_accept move=%0d got none exp accept", i); end
    end
    bus.req1_valid = 1'b0;
    clk_step();
    clk_step();
    total++;
    if ({bus.mv_opcode, bus.mv_in, bus.rsp_valid, bus.rsp_data, bus.busy} !==
        {2'b01, 32'h3, 1'b1, 32'h1, 1'b1}) begin
      bad++; $display("FAIL bp_wait got op=%b in=%h rv=%b d=%h busy=%b exp 01 3 1 1 1",
                      bus.mv_opcode, bus.mv_in, bus.rsp_valid, bus.rsp_data, bus.busy);
    end
    bus.req1_valid = 1'b1; bus.req1_data = 32'h44;
    #1;
    total++;
    if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL bp_no_accept got=%b exp=0", bus.req1_ready); end
    bus.req1_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10 && k < 3; c++) begin
      clk_step();
      if (s_pop) begin
        total++;
        if (exp_q.size() == 0 || s_rsp !== exp_q[0] || s_rsp.data !== 32'(k + 1)) begin
          bad++; $display("FAIL bp_order idx=%0d got=%h exp data=%0d", k, s_rsp, k + 1);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        k++;
      end
    end
    total++;
    if (k != 3 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL bp_drain got pops=%0d busy=%b exp 3/0", k, bus.busy);
    end
  endtask

  task automatic test_flush();
    logic got;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.req0_valid = 1'b1; bus.req0_data = $urandom; bus.req0_tag = 5'($urandom);
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin clk_step(); got = s_acc0; end
      total++;
      if (!got) begin bad++; $display("FAIL flush_setup move=%0d got none exp accept", i); end
    end
    bus.req0_valid = 1'b0;
    clk_step();
    flush = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_data = 32'hC0DE_0001; bus.req1_tag = 5'd17;
    #1;
    total++;
    if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL flush_no_accept got=%b exp=0", bus.req1_ready); end
    clk_step();
    flush = 1'b0;
    total++;
    if ({bus.rsp_valid, bus.busy, bus.mv_opcode} !== 4'b0000) begin
      bad++; $display("FAIL flush_clear got rv=%b busy=%b op=%b exp 0 0 00", bus.rsp_valid, bus.busy, bus.mv_opcode);
    end
    bus.req0_valid = 1'b1; bus.req0_data = 32'hC0DE_0000; bus.req0_tag = 5'd16;
    clk_step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    total++;
    if ({s_acc0, s_acc1} !== 2'b01) begin
      bad++; $display("FAIL flush_pointer got acc0=%b acc1=%b exp 0 1", s_acc0, s_acc1);
    end
    bus.rsp_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      clk_step();
      got = s_pop;
    end
    total++;
    if (!got || exp_q.size() == 0 || s_rsp !== exp_q[0] || s_rsp !== {32'hC0DE_0001, 5'd17, 1'b1}) begin
      bad++; $display("FAIL flush_next got pop=%b rsp=%h exp c0de0001/17/1", got, s_rsp);
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_idle got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_random();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    s_acc0 = 1'b0; s_acc1 = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!bus.req0_valid || s_acc0) begin
        bus.req0_valid = ($urandom_range(0, 2) != 0);
        bus.req0_data = $urandom; bus.req0_tag = 5'($urandom);
      end
      if (!bus.req1_valid || s_acc1) begin
        bus.req1_valid = ($urandom_range(0, 2) != 0);
        bus.req1_data = $urandom; bus.req1_tag = 5'($urandom);
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 31) == 0);
      clk_step();
      total++;
      if (s_both_rdy !== 1'b0) begin bad++; $display("FAIL rnd_both_ready cyc=%0d", i); end
      if (s_flush) begin
        total++;
        if ((s_acc0 | s_acc1) !== 1'b0) begin bad++; $display("FAIL rnd_flush_accept cyc=%0d got accept exp none", i); end
      end else if (s_acc0 | s_acc1) begin
        total++;
        if (s_acc1 !== s_exp_win1) begin
          bad++; $display("FAIL rnd_grant cyc=%0d got req%0d exp req%0d", i, s_acc1, s_exp_win1);
        end
      end
      if (s_pop && !s_flush) begin
        total++;
        if (exp_q.size() == 0 || s_rsp !== exp_q[0]) begin
          bad++; $display("FAIL rnd_rsp cyc=%0d got=%h exp=%h", i, s_rsp, exp_q.size() ? exp_q[0] : '0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      total++;
      if (bus.busy !== (exp_q.size() != 0)) begin
        bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", i, bus.busy, exp_q.size() != 0);
      end
    end
    flush = 1'b0; bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.rsp_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() != 0; c++) begin
      clk_step();
      if (s_pop) begin
        total++;
        if (s_rsp !== exp_q[0]) begin bad++; $display("FAIL rnd_drain got=%h exp=%h", s_rsp, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    total++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL rnd_end got left=%0d busy=%b exp 0/0", exp_q.size(), bus.busy);
    end
  endtask

`ifdef FPU_MOVE_PERF_CNT_EN
  task automatic test_perf();
    logic got;
    logic dirs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rst_l = 1'b1;
    clk_step();
    rst_l = 1'b0;
    total++;
    if ({perf_mv_cnt0, perf_mv_cnt1} !== 64'd0) begin
      bad++; $display("FAIL perf_reset got=%0d/%0d exp 0/0", perf_mv_cnt0, perf_mv_cnt1);
    end
    bus.rsp_ready = 1'b1;
    foreach (dirs[i]) begin
      bus.req0_valid = !dirs[i]; bus.req1_valid = dirs[i];
      bus.req0_data = $urandom; bus.req1_data = $urandom;
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin clk_step(); got = s_acc0 | s_acc1; end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      total++;
      if (!got) begin bad++; $display("FAIL perf_accept move=%0d got none exp accept", i); end
    end
    repeat (3) clk_step();
    total++;
    if (perf_mv_cnt0 !== 32'd3 || perf_mv_cnt1 !== 32'd2) begin
      bad++; $display("FAIL perf_count got=%0d/%0d exp 3/2", perf_mv_cnt0, perf_mv_cnt1);
    end
    flush = 1'b1;
    clk_step();
    flush = 1'b0;
    total++;
    if (perf_mv_cnt0 !== 32'd3 || perf_mv_cnt1 !== 32'd2) begin
      bad++; $display("FAIL perf_flush got=%0d/%0d exp 3/2", perf_mv_cnt0, perf_mv_cnt1);
    end
  endtask
`endif

  initial begin
    rst_l = 1'b1; flush = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_tag = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_tag = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_random();
`ifdef FPU_MOVE_PERF_CNT_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
